// File: rtl/alarm_pkg.sv
// Shared constants for the alarm ring controller: FSM state encodings and
// default timing parameters.
package alarm_pkg;

    localparam logic [1:0] ST_DISABLED = 2'b00;
    localparam logic [1:0] ST_ARMED    = 2'b01;
    localparam logic [1:0] ST_RINGING  = 2'b10;
    localparam logic [1:0] ST_SNOOZING = 2'b11;

    localparam int SNOOZE_SECS_DEF  = 300;
    localparam int RING_TIMEOUT_DEF = 60;
    localparam int MAX_SNOOZE_DEF   = 3;
    localparam int TW_DEF           = 10;

endpackage

// File: rtl/rise_edge.sv
// One-bit registered rising-edge detector. RESET_VAL sets the remembered
// level after reset; a value of 1 means a level already high when reset is
// released is not reported as an edge.
module rise_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic Resetn,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    // Next value of the delayed level is simply the current level.
    always_comb begin
        d_d = d;
    end

    // Delayed copy of the input level.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: arms on enable, rings when the clock reaches the alarm
// time, and handles stop, snooze (limited count) and unanswered-ring timeout
// using a single shared down-timer clocked by the 1 Hz tick.
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SECS  = SNOOZE_SECS_DEF,
    parameter int RING_TIMEOUT = RING_TIMEOUT_DEF,
    parameter int MAX_SNOOZE   = MAX_SNOOZE_DEF,
    parameter int TW           = TW_DEF
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic          tick_1hz,
    input  logic          enable_sw,
    input  logic          stop_btn,
    input  logic          snooze_btn,
    input  logic [5:0]    clock_sec,
    input  logic [5:0]    clock_min,
    input  logic [5:0]    alarm_sec,
    input  logic [5:0]    alarm_min,
    output logic [1:0]    state,
    output logic          armed_led,
    output logic          ring,
    output logic          buzzer,
    output logic [2:0]    snooze_count,
    output logic          missed,
    output logic [TW-1:0] remaining
);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    snooze_count_q, snooze_count_d;
    logic          missed_q, missed_d;
    logic          beep_q, beep_d;

    logic eq;
    logic match_rise;
    logic stop_rise;
    logic snooze_rise;
    logic expire;
    logic snooze_ok;

    assign eq = (clock_min == alarm_min) && (clock_sec == alarm_sec);

    // Buttons remember "high" through reset so a held button is not a press.
    rise_edge #(.RESET_VAL(1'b1)) u_stop_edge (
        .clk(clk), .Resetn(Resetn), .d(stop_btn), .rise(stop_rise)
    );
    rise_edge #(.RESET_VAL(1'b1)) u_snooze_edge (
        .clk(clk), .Resetn(Resetn), .d(snooze_btn), .rise(snooze_rise)
    );
    rise_edge #(.RESET_VAL(1'b0)) u_eq_edge (
        .clk(clk), .Resetn(Resetn), .d(eq), .rise(match_rise)
    );

    assign expire    = tick_1hz && (timer_q == TW'(1));
    assign snooze_ok = (snooze_count_q < 3'(MAX_SNOOZE));

    // Next-state logic; branch order encodes event priority.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        snooze_count_d = snooze_count_q;
        missed_d       = missed_q;
        beep_d         = beep_q;
        if (!enable_sw) begin
            state_d        = ST_DISABLED;
            timer_d        = '0;
            snooze_count_d = 3'd0;
            missed_d       = 1'b0;
            beep_d         = 1'b0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (match_rise) begin
                        state_d  = ST_RINGING;
                        timer_d  = TW'(RING_TIMEOUT);
                        beep_d   = 1'b1;
                        missed_d = 1'b0;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (stop_rise) begin
                        state_d        = ST_ARMED;
                        timer_d        = '0;
                        snooze_count_d = 3'd0;
                        beep_d         = 1'b0;
                    end else if (expire) begin
                        state_d        = ST_ARMED;
                        timer_d        = '0;
                        snooze_count_d = 3'd0;
                        missed_d       = 1'b1;
                        beep_d         = 1'b0;
                    end else if (snooze_rise && snooze_ok) begin
                        state_d        = ST_SNOOZING;
                        timer_d        = TW'(SNOOZE_SECS);
                        snooze_count_d = snooze_count_q + 3'd1;
                        beep_d         = 1'b0;
                    end else if (tick_1hz) begin
                        timer_d = (timer_q != '0) ? (timer_q - TW'(1)) : timer_q;
                        beep_d  = ~beep_q;
                    end else begin
                        state_d = ST_RINGING;
                    end
                end
                ST_SNOOZING: begin
                    if (stop_rise) begin
                        state_d        = ST_ARMED;
                        timer_d        = '0;
                        snooze_count_d = 3'd0;
                    end else if (expire) begin
                        state_d = ST_RINGING;
                        timer_d = TW'(RING_TIMEOUT);
                        beep_d  = 1'b1;
                    end else if (tick_1hz) begin
                        timer_d = (timer_q != '0) ? (timer_q - TW'(1)) : timer_q;
                    end else begin
                        state_d = ST_SNOOZING;
                    end
                end
                default: begin
                    state_d        = ST_DISABLED;
                    timer_d        = '0;
                    snooze_count_d = 3'd0;
                    missed_d       = 1'b0;
                    beep_d         = 1'b0;
                end
            endcase
        end
    end

    // State, timer and counter registers.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q        <= ST_DISABLED;
            timer_q        <= '0;
            snooze_count_q <= 3'd0;
            missed_q       <= 1'b0;
            beep_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            snooze_count_q <= snooze_count_d;
            missed_q       <= missed_d;
            beep_q         <= beep_d;
        end
    end

    assign state        = state_q;
    assign armed_led    = (state_q != ST_DISABLED);
    assign ring         = (state_q == ST_RINGING);
    assign buzzer       = (state_q == ST_RINGING) && beep_q;
    assign snooze_count = snooze_count_q;
    assign missed       = missed_q;
    assign remaining    = ((state_q == ST_RINGING) || (state_q == ST_SNOOZING)) ? timer_q : '0;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller with an event-level reference
// model compared every clock, plus hand-computed checkpoints.
module tb_alarm_ring_controller;

    localparam int SNZ = 3;
    localparam int RTO = 5;
    localparam int MAXS = 2;
    localparam int TW = 10;

    logic clk = 1'b0;
    logic Resetn;
    logic tick_1hz = 1'b0;
    logic enable_sw = 1'b0;
    logic stop_btn = 1'b0;
    logic snooze_btn = 1'b0;
    logic [5:0] clock_sec = 6'd4;
    logic [5:0] clock_min = 6'd0;
    logic [5:0] alarm_sec = 6'd5;
    logic [5:0] alarm_min = 6'd0;
    logic [1:0] state_o;
    logic armed_led_o, ring_o, buzzer_o, missed_o;
    logic [2:0] snooze_count_o;
    logic [TW-1:0] remaining_o;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alarm_ring_controller #(
        .SNOOZE_SECS(SNZ), .RING_TIMEOUT(RTO), .MAX_SNOOZE(MAXS), .TW(TW)
    ) dut (
        .clk(clk), .Resetn(Resetn), .tick_1hz(tick_1hz), .enable_sw(enable_sw),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .clock_sec(clock_sec), .clock_min(clock_min),
        .alarm_sec(alarm_sec), .alarm_min(alarm_min),
        .state(state_o), .armed_led(armed_led_o), .ring(ring_o), .buzzer(buzzer_o),
        .snooze_count(snooze_count_o), .missed(missed_o), .remaining(remaining_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 off, 1 waiting, 2 ringing, 3 snoozing.
    localparam int EV_NONE = 0, EV_OFF = 1, EV_WAKE = 2, EV_STOP = 3, EV_EXPIRE = 4,
                   EV_SNOOZE = 5, EV_MATCH = 6, EV_TICK = 7;
    int m_mode, m_timer, m_count;
    bit m_missed, m_beep, p_eq, p_stop, p_snz;

    always @(posedge clk or negedge Resetn) begin
        int ev, n_mode, n_timer, n_count;
        bit n_missed, n_beep, eq, mr, sr, nr;
        if (!Resetn) begin
            m_mode <= 0; m_timer <= 0; m_count <= 0;
            m_missed <= 1'b0; m_beep <= 1'b0;
            p_eq <= 1'b0; p_stop <= 1'b1; p_snz <= 1'b1;
        end else begin
            eq = (clock_min == alarm_min) && (clock_sec == alarm_sec);
            mr = eq && !p_eq;
            sr = stop_btn && !p_stop;
            nr = snooze_btn && !p_snz;
            if (!enable_sw)                                   ev = EV_OFF;
            else if (m_mode == 0)                             ev = EV_WAKE;
            else if (m_mode >= 2 && sr)                       ev = EV_STOP;
            else if (m_mode >= 2 && tick_1hz && m_timer == 1) ev = EV_EXPIRE;
            else if (m_mode == 2 && nr && m_count < MAXS)     ev = EV_SNOOZE;
            else if (m_mode == 1 && mr)                       ev = EV_MATCH;
            else if (m_mode >= 2 && tick_1hz)                 ev = EV_TICK;
            else                                              ev = EV_NONE;
            n_mode = m_mode; n_timer = m_timer; n_count = m_count;
            n_missed = m_missed; n_beep = m_beep;
            case (ev)
                EV_OFF: begin n_mode = 0; n_timer = 0; n_count = 0; n_missed = 0; n_beep = 0; end
                EV_WAKE: n_mode = 1;
                EV_STOP: begin n_mode = 1; n_timer = 0; n_count = 0; end
                EV_EXPIRE: begin
                    if (m_mode == 2) begin n_mode = 1; n_timer = 0; n_count = 0; n_missed = 1; end
                    else begin n_mode = 2; n_timer = RTO; n_beep = 1; end
                end
                EV_SNOOZE: begin n_mode = 3; n_timer = SNZ; n_count = m_count + 1; end
                EV_MATCH: begin n_mode = 2; n_timer = RTO; n_beep = 1; n_missed = 0; end
                EV_TICK: begin
                    if (m_timer > 0) n_timer = m_timer - 1;
                    if (m_mode == 2) n_beep = !m_beep;
                end
                default: ;
            endcase
            m_mode <= n_mode; m_timer <= n_timer; m_count <= n_count;
            m_missed <= n_missed; m_beep <= n_beep;
            p_eq <= eq; p_stop <= stop_btn; p_snz <= snooze_btn;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("m_state", int'(state_o), m_mode);
            chk("m_armed_led", int'(armed_led_o), int'(m_mode != 0));
            chk("m_ring", int'(ring_o), int'(m_mode == 2));
            chk("m_buzzer", int'(buzzer_o), int'(m_mode == 2 && m_beep));
            chk("m_snooze_count", int'(snooze_count_o), m_count);
            chk("m_missed", int'(missed_o), int'(m_missed));
            chk("m_remaining", int'(remaining_o), (m_mode >= 2) ? m_timer : 0);
        end
    end

    task automatic cyc();
        @(negedge clk);
        tick_1hz = (tick_cnt == 9);
        tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
    endtask

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    task automatic clk1();
        cyc();
        post();
    endtask

    task automatic to_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = tick_1hz;
            post();
        end
        if (!seen) chk("tick_wait_timeout", 0, 1);
    endtask

    task automatic align(input int target);
        for (int i = 0; i < 12 && tick_cnt != target; i++) clk1();
        if (tick_cnt != target) chk("align_timeout", tick_cnt, target);
    endtask

    task automatic rematch();
        cyc(); clock_sec = 6'd6; post();
        cyc(); clock_sec = 6'd5; post();
    endtask

    initial begin
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_remaining", int'(remaining_o), 0);
        clk1(); clk1();
        cyc(); Resetn = 1'b1; post();
        clk1();
        chk("disabled_state", int'(state_o), 0);
        cyc(); enable_sw = 1'b1; post();
        chk("armed_state", int'(state_o), 1);
        chk("armed_led", int'(armed_led_o), 1);

        // 1. clock steps 00:04 -> 00:05
        cyc(); clock_sec = 6'd5; post();
        chk("t1_state", int'(state_o), 2);
        chk("t1_ring", int'(ring_o), 1);
        chk("t1_buzzer", int'(buzzer_o), 1);
        chk("t1_remaining", int'(remaining_o), 5);
        to_tick();
        chk("t1_tick1_buzzer", int'(buzzer_o), 0);
        chk("t1_tick1_remaining", int'(remaining_o), 4);
        to_tick();
        chk("t1_tick2_buzzer", int'(buzzer_o), 1);

        // 2. unanswered ring times out
        to_tick(); to_tick(); to_tick();
        chk("t2_state", int'(state_o), 1);
        chk("t2_missed", int'(missed_o), 1);
        chk("t2_ring", int'(ring_o), 0);
        chk("t2_count", int'(snooze_count_o), 0);

        // 3. snooze twice, third snooze ignored
        rematch();
        chk("t3_ring_state", int'(state_o), 2);
        chk("t3_missed_cleared", int'(missed_o), 0);
        align(3);
        cyc(); snooze_btn = 1'b1; post();
        chk("t3_snz1_state", int'(state_o), 3);
        chk("t3_snz1_remaining", int'(remaining_o), 3);
        chk("t3_snz1_count", int'(snooze_count_o), 1);
        cyc(); snooze_btn = 1'b0; post();
        to_tick(); to_tick(); to_tick();
        chk("t3_back_state", int'(state_o), 2);
        chk("t3_back_remaining", int'(remaining_o), 5);
        align(3);
        cyc(); snooze_btn = 1'b1; post();
        chk("t3_snz2_count", int'(snooze_count_o), 2);
        cyc(); snooze_btn = 1'b0; post();
        to_tick(); to_tick(); to_tick();
        align(3);
        cyc(); snooze_btn = 1'b1; post();
        chk("t3_snz3_state", int'(state_o), 2);
        chk("t3_snz3_count", int'(snooze_count_o), 2);
        cyc(); snooze_btn = 1'b0; post();

        // 4. stop coincides with the expiring tick
        to_tick(); to_tick(); to_tick(); to_tick();
        chk("t4_remaining", int'(remaining_o), 1);
        align(9);
        cyc(); stop_btn = 1'b1; post();
        chk("t4_state", int'(state_o), 1);
        chk("t4_missed", int'(missed_o), 0);
        chk("t4_count", int'(snooze_count_o), 0);
        cyc(); stop_btn = 1'b0; post();

        // 5. disable while snoozing, re-enable while clock == alarm
        rematch();
        align(3);
        cyc(); snooze_btn = 1'b1; post();
        chk("t5_snoozing", int'(state_o), 3);
        cyc(); snooze_btn = 1'b0; enable_sw = 1'b0; post();
        chk("t5_state", int'(state_o), 0);
        chk("t5_count", int'(snooze_count_o), 0);
        chk("t5_remaining", int'(remaining_o), 0);
        chk("t5_led", int'(armed_led_o), 0);
        cyc(); enable_sw = 1'b1; post();
        clk1(); clk1(); clk1();
        chk("t5_reenable_state", int'(state_o), 1);
        chk("t5_reenable_ring", int'(ring_o), 0);

        // 6. reset mid-ring with stop held
        rematch();
        chk("t6_ringing", int'(state_o), 2);
        @(negedge clk);
        Resetn = 1'b0; stop_btn = 1'b1;
        #1;
        chk("t6_rst_state", int'(state_o), 0);
        chk("t6_rst_ring", int'(ring_o), 0);
        chk("t6_rst_buzzer", int'(buzzer_o), 0);
        chk("t6_rst_remaining", int'(remaining_o), 0);
        clk1(); clk1();
        cyc(); Resetn = 1'b1; post();
        clk1(); clk1();
        chk("t6_after_state", int'(state_o), 1);
        cyc(); stop_btn = 1'b0; post();
        clk1(); clk1();
        chk("t6_final_state", int'(state_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
